// File: rtl/show_pkg.sv
// Shared types and default timing constants for the show director and its ms timer.
package show_pkg;

    localparam int MS_W            = 20;
    localparam int DEF_CLKS_PER_MS = 5000;
    localparam int DEF_GAP_MS      = 2000;
    localparam int DEF_TIMEOUT_MS  = 600000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LAUNCH,
        ST_PLAY,
        ST_GAP
    } state_t;

endpackage

// File: rtl/ms_timer.sv
// Millisecond timebase: a cycle prescaler producing a one-cycle tick and a saturating
// ms counter. i_clr restarts both so a new interval always begins at a full millisecond.
module ms_timer
    import show_pkg::*;
#(
    parameter int CLKS_PER_MS = DEF_CLKS_PER_MS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    output logic            o_tick,
    output logic [MS_W-1:0] o_ms_count
);

    localparam int CYC_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    logic [CYC_W-1:0] r_cyc;
    logic [MS_W-1:0]  r_ms;
    logic             w_wrap;

    assign w_wrap = (r_cyc == CYC_W'(CLKS_PER_MS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
            r_ms  <= '0;
        end else if (i_clr) begin
            r_cyc <= '0;
            r_ms  <= '0;
        end else begin
            r_cyc <= w_wrap ? '0 : r_cyc + CYC_W'(1);
            if (w_wrap && (r_ms != '1)) begin
                r_ms <= r_ms + MS_W'(1);
            end
        end
    end

    assign o_tick     = w_wrap;
    assign o_ms_count = r_ms;

endmodule

// File: rtl/show_director.sv
// Playlist sequencer: launches each enabled song slot in turn, muxes its lights while it
// plays, and inserts a silent gap after it. Define SHOW_DIRECTOR_LOOP_EN to repeat the playlist.
module show_director
    import show_pkg::*;
#(
    parameter int NUM_SONGS   = 4,
    parameter int CLKS_PER_MS = DEF_CLKS_PER_MS,
    parameter int GAP_MS      = DEF_GAP_MS,
    parameter int TIMEOUT_MS  = DEF_TIMEOUT_MS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NUM_SONGS-1:0]   song_en,
    input  logic [NUM_SONGS-1:0]   finished,
    input  logic [8*NUM_SONGS-1:0] light_in,
    output logic [NUM_SONGS-1:0]   go,
    output logic [7:0]             light,
    output logic                   busy,
    output logic [1:0]             song_idx,
    output logic                   timeout_flag
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_SONGS - 1);

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [NUM_SONGS-1:0]  r_go;
    logic                  r_tflag;

    logic                  w_en;
    logic                  w_fin;
    logic [7:0]            w_slot_light;
    logic [NUM_SONGS-1:0]  w_go_sel;
    logic                  w_tick;
    logic [MS_W-1:0]       w_ms;
    logic                  w_timeout;
    logic                  w_gap_done;
    logic                  w_clr;
    logic                  w_sel_wrap;
    logic                  w_gap_wrap;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_en         = 1'b0;
        w_fin        = 1'b0;
        w_slot_light = '0;
        w_go_sel     = '0;
        for (int k = 0; k < NUM_SONGS; k++) begin
            if (r_idx == 2'(k)) begin
                w_en         = song_en[k];
                w_fin        = finished[k];
                w_slot_light = light_in[8*k +: 8];
                w_go_sel[k]  = 1'b1;
            end
        end
    end

`ifdef SHOW_DIRECTOR_LOOP_EN
    assign w_sel_wrap = |song_en;
    assign w_gap_wrap = 1'b1;
`else
    assign w_sel_wrap = 1'b0;
    assign w_gap_wrap = 1'b0;
`endif

    assign w_timeout  = (w_ms == MS_W'(TIMEOUT_MS));
    assign w_gap_done = (GAP_MS == 0) ? 1'b1 : (w_tick && (w_ms == MS_W'(GAP_MS - 1)));

    // Timer runs only while a song plays or a gap elapses; it restarts on every PLAY exit.
    assign w_clr = ((r_state != ST_PLAY) && (r_state != ST_GAP)) ||
                   ((r_state == ST_PLAY) && (w_fin || w_timeout));

    ms_timer #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_ms_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .o_tick     (w_tick),
        .o_ms_count (w_ms)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_go    <= '0;
            r_tflag <= 1'b0;
        end else begin
            r_go <= '0;
            if ((r_state != ST_IDLE) && stop) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_SELECT;
                            r_idx   <= '0;
                            r_tflag <= 1'b0;
                        end
                    end
                    ST_SELECT: begin
                        if (w_en) begin
                            r_state <= ST_LAUNCH;
                            r_go    <= w_go_sel;
                        end else if (r_idx == LAST_IDX) begin
                            if (w_sel_wrap) r_idx   <= '0;
                            else            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                    ST_LAUNCH: r_state <= ST_PLAY;
                    ST_PLAY: begin
                        // A finish in the timeout cycle wins and leaves the flag untouched.
                        if (w_fin) begin
                            r_state <= ST_GAP;
                        end else if (w_timeout) begin
                            r_state <= ST_GAP;
                            r_tflag <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_done) begin
                            if (r_idx != LAST_IDX) begin
                                r_idx   <= r_idx + 2'd1;
                                r_state <= ST_SELECT;
                            end else if (w_gap_wrap) begin
                                r_idx   <= '0;
                                r_state <= ST_SELECT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign go           = r_go;
    assign busy         = (r_state != ST_IDLE);
    assign song_idx     = r_idx;
    assign timeout_flag = r_tflag;
    assign light        = (r_state == ST_PLAY) ? w_slot_light : 8'h00;

endmodule
